// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/capture stage: opcodes, widths and FSM states.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int RES_W  = 64;
  localparam int SEL_W  = 4;

  localparam logic [SEL_W-1:0] OP_ADD   = 4'b0000;
  localparam logic [SEL_W-1:0] OP_SUB   = 4'b0001;
  localparam logic [SEL_W-1:0] OP_MUL   = 4'b0111;
  localparam logic [SEL_W-1:0] OP_PASSA = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int max_cyc(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that times the ALU settle window; done is high while the count is 0.
module alu_lat_counter #(
  parameter int MAX_CYC = 3,
  parameter int W       = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/alu_op_sequencer.sv
// Issue/capture stage for the external 32-bit ALU: registers a command, holds it on the
// ALU pins for the opcode's settle window, captures the result and hands it downstream.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int SETTLE_CYC = 1,
  parameter int MUL_CYC    = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_sel,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [63:0]      alu_out,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_carry,
  output logic [3:0]       out_sel,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  localparam int MAX_CYC = max_cyc(SETTLE_CYC, MUL_CYC);
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  generate
    if (SETTLE_CYC < 1 || MUL_CYC < 1) begin : g_bad_param
      $error("alu_op_sequencer: SETTLE_CYC and MUL_CYC must both be >= 1");
    end
  endgenerate

  state_t        state;
  logic          accept;
  logic          lat_done;
  logic [CW-1:0] lat_m1;

  // in_ready is gated by rst_n so every output reads 0 while reset is held.
  assign in_ready = rst_n & ((state == S_IDLE) | ((state == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;
  assign busy     = (state == S_EXEC) | (state == S_DONE);
  assign lat_m1   = (in_sel == OP_MUL) ? CW'(MUL_CYC - 1) : CW'(SETTLE_CYC - 1);

  alu_lat_counter #(
    .MAX_CYC (MAX_CYC),
    .W       (CW)
  ) u_lat_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (lat_m1),
    .done     (lat_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_sel    <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_a   <= in_a;
        alu_b   <= in_b;
        alu_sel <= in_sel;
      end
      case (state)
        S_IDLE: begin
          if (accept) state <= S_EXEC;
        end
        S_EXEC: begin
          if (lat_done) begin
            out_result <= alu_out;
            out_carry  <= (alu_sel == OP_ADD) ? alu_carry : 1'b0;
            out_sel    <= alu_sel;
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          // Handoff and a back-to-back accept can share this cycle.
          if (out_ready) begin
            out_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= accept ? S_EXEC : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a stand-in ALU and randomized traffic.
module tb_alu_op_sequencer;

  localparam int SETTLE_CYC = 1;
  localparam int MUL_CYC    = 3;
  localparam int CNT_W      = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a;
  logic [31:0]      in_b;
  logic [3:0]       in_sel;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [3:0]       alu_sel;
  logic [63:0]      alu_out;
  logic             alu_carry;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_result;
  logic             out_carry;
  logic [3:0]       out_sel;
  logic             busy;
  logic [CNT_W-1:0] op_count;

  alu_op_sequencer #(
    .SETTLE_CYC (SETTLE_CYC),
    .MUL_CYC    (MUL_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sel     (in_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_out    (alu_out),
    .alu_carry  (alu_carry),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_sel    (out_sel),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Stand-in ALU: add with carry, 64-bit multiply, xor for everything else; carry is
  // driven high for non-add opcodes so the sequencer's forcing to 0 is visible.
  logic [32:0] sum33;
  always_comb begin
    sum33     = {1'b0, alu_a} + {1'b0, alu_b};
    alu_out   = {32'b0, alu_a ^ alu_b};
    alu_carry = 1'b1;
    if (alu_sel == 4'b0000) begin
      alu_out   = {32'b0, sum33[31:0]};
      alu_carry = sum33[32];
    end else if (alu_sel == 4'b0111) begin
      alu_out = {32'b0, alu_a} * {32'b0, alu_b};
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  sel;
    logic [63:0] res;
    logic        carry;
    int          acc;
    int          lat;
  } exp_t;

  exp_t             q[$];
  int               total = 0;
  int               bad = 0;
  int               cyc = 0;
  int               rmode = 0;
  int               handoffs = 0;
  logic [CNT_W-1:0] exp_count = '0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    exp_t            e;
    longint unsigned ua;
    longint unsigned ub;
    longint unsigned s;
    ua      = a;
    ub      = b;
    e.a     = a;
    e.b     = b;
    e.sel   = sel;
    e.acc   = 0;
    e.carry = 1'b0;
    if (sel == 4'd0) begin
      s       = ua + ub;
      e.res   = s % 64'h1_0000_0000;
      e.carry = (s >= 64'h1_0000_0000);
    end else if (sel == 4'd7) begin
      e.res = ua * ub;
    end else begin
      e.res = ua ^ ub;
    end
    e.lat = (sel == 4'd7) ? MUL_CYC : SETTLE_CYC;
    return e;
  endfunction

  // out_ready driver: 0 = always ready, 1 = random, 2 = stalled
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every handoff and checks timing/stability rules.
  initial begin
    logic        prev_v;
    logic        hold_v;
    logic [63:0] hold_res;
    logic [3:0]  hold_sel;
    prev_v = 1'b0;
    hold_v = 1'b0;
    hold_res = '0;
    hold_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        hold_v = 1'b0;
      end else begin
        chk("in_ready rule", 64'(in_ready), 64'(!busy || (out_valid && out_ready)));
        chk("op_count", 64'(op_count), 64'(exp_count));
        if (busy && q.size() > 0) begin
          chk("alu_a stable", 64'(alu_a), 64'(q[0].a));
          chk("alu_b stable", 64'(alu_b), 64'(q[0].b));
          chk("alu_sel stable", 64'(alu_sel), 64'(q[0].sel));
        end
        if (hold_v) begin
          chk("out_valid held", 64'(out_valid), 64'd1);
          chk("out_result held", out_result, hold_res);
          chk("out_sel held", 64'(out_sel), 64'(hold_sel));
        end
        if (out_valid && q.size() == 0) begin
          chk("spurious out_valid", 64'(out_valid), 64'd0);
        end else if (out_valid) begin
          if (!prev_v) chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat + 1));
          chk("out_result", out_result, q[0].res);
          chk("out_carry", 64'(out_carry), 64'(q[0].carry));
          chk("out_sel", 64'(out_sel), 64'(q[0].sel));
        end
        hold_v = 1'b0;
        if (out_valid && out_ready) begin
          if (q.size() > 0) begin
            $display("handoff sel=%h a=%h b=%h result=%h carry=%0b count=%0d",
                     q[0].sel, q[0].a, q[0].b, out_result, out_carry, op_count);
            void'(q.pop_front());
          end
          exp_count = exp_count + 1'b1;
          handoffs++;
        end else if (out_valid) begin
          hold_v   = 1'b1;
          hold_res = out_result;
          hold_sel = out_sel;
        end
        prev_v = out_valid;
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
    exp_t e;
    int   acc;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_sel   = sel;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        e = model(a, b, sel);
        e.acc = acc;
        q.push_back(e);
        return;
      end
      @(posedge clk);
      #1;
    end
    chk("accept timeout in_ready", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !busy) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("drain timeout busy", 64'(busy), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " alu_a"}, 64'(alu_a), 64'd0);
    chk({tag, " alu_b"}, 64'(alu_b), 64'd0);
    chk({tag, " alu_sel"}, 64'(alu_sel), 64'd0);
    chk({tag, " out_result"}, out_result, 64'd0);
    chk({tag, " out_carry"}, 64'(out_carry), 64'd0);
    chk({tag, " out_sel"}, 64'(out_sel), 64'd0);
    chk({tag, " op_count"}, 64'(op_count), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d want < 100000", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [3:0]  rs;
    logic [CNT_W-1:0] c0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_sel   = '0;
    rmode    = 0;
    repeat (3) @(posedge clk);
    #2;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ADD overflow into carry
    send(32'hFFFF_FFFF, 32'h1, 4'b0000);
    drain();
    chk("t1 op_count", 64'(op_count), 64'd1);

    // multiply with full 64-bit product
    send(32'h0001_0000, 32'h0001_0000, 4'b0111);
    drain();

    // stalled downstream for 5 cycles
    rmode = 2;
    send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 4'b0101);
    for (int n = 0; n < 50 && !out_valid; n++) @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("t3 in_ready stalled", 64'(in_ready), 64'd0);
      chk("t3 out_result", out_result, 64'h0000_0000_FFFF_FFFF);
    end
    @(posedge clk);
    #1;
    rmode = 0;
    drain();

    // back-to-back with in_valid held
    c0 = op_count;
    send(32'h1234_5678, 32'h0000_0010, 4'b0000);
    send(32'h0000_0003, 32'h0000_0005, 4'b0111);
    send(32'hDEAD_BEEF, 32'hFFFF_0000, 4'b1111);
    drain();
    chk("t4 op_count delta", 64'(CNT_W'(op_count - c0)), 64'd3);

    // reset in the middle of a multiply
    send(32'h0000_0007, 32'h0000_0009, 4'b0111);
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_count = '0;
    handoffs  = 0;
    check_all_zero("t5 abort");
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t5 no result after abort", 64'(out_valid), 64'd0);

    // randomized traffic, long enough to wrap op_count
    rmode = 1;
    for (int i = 0; i < 320; i++) begin
      case ($urandom_range(0, 4))
        0: rs = 4'b0000;
        1: rs = 4'b0111;
        2: rs = 4'b0101;
        default: rs = 4'($urandom_range(0, 15));
      endcase
      ra = (($urandom_range(0, 7)) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = (($urandom_range(0, 7)) == 0) ? 32'hFFFF_FFFF : $urandom;
      send(ra, rb, rs);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    rmode = 0;
    drain();
    chk("wrap handoffs", 64'(handoffs >= (1 << CNT_W)), 64'd1);
    chk("op_count wrapped", 64'(op_count), 64'(handoffs % (1 << CNT_W)));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
